// File: rtl/issueint_pipe_pkg.sv
// Shared opcode/funct encodings and result-entry layout for the integer issue pipe.
// Entry layout, LSB first: overflow, branch, taken, tag, data.
package issueint_pipe_pkg;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] OPCODE_BEQ = 6'h04;
    localparam logic [5:0] OPCODE_BNE = 6'h05;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;
    localparam logic [5:0] FUNCT_SLTU = 6'h2b;

    localparam int unsigned ENT_FLAG_W = 3;
    localparam int unsigned ENT_OVF    = 0;
    localparam int unsigned ENT_BR     = 1;
    localparam int unsigned ENT_TAKEN  = 2;

endpackage

// File: rtl/issueint_resq.sv
// Circular result FIFO for the integer issue pipe; flush overrides push and pop.
module issueint_resq #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
            count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/issueint_pipe.sv
// Pipelined integer issue unit: inline ALU, EX register, result queue toward the CDB.
// Define ISSUEINT_BYPASS_EN to let the EX entry drive the outputs when the queue is empty.
module issueint_pipe
    import issueint_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned OPC_W  = 6,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPC_W-1:0]            in_opcode,
    input  logic [DATA_W-1:0]           in_rsdata,
    input  logic [DATA_W-1:0]           in_rtdata,
    input  logic [TAG_W-1:0]            in_rdtag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [TAG_W-1:0]            out_rdtag,
    output logic                        out_overflow,
    output logic                        out_branch,
    output logic                        out_branch_taken,
    output logic [$clog2(QDEPTH+2)-1:0] out_count
);

    localparam int unsigned ENT_W  = DATA_W + TAG_W + ENT_FLAG_W;
    localparam int unsigned SH_W   = $clog2(DATA_W);
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 2);
    localparam int unsigned QCNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned MSB    = DATA_W - 1;

    logic [DATA_W-1:0]        sum, diff, alu_data;
    logic signed [DATA_W-1:0] rt_s;
    logic [SH_W-1:0]          shamt;
    logic                     alu_ovf, alu_br, alu_tk, slt, sltu;
    logic [ENT_W-1:0]         alu_entry;

    assign sum   = in_rsdata + in_rtdata;
    assign diff  = in_rsdata - in_rtdata;
    assign rt_s  = in_rtdata;
    assign shamt = in_rsdata[SH_W-1:0];
    assign slt   = $signed(in_rsdata) < $signed(in_rtdata);
    assign sltu  = in_rsdata < in_rtdata;

    always_comb begin
        alu_data = '0;
        alu_ovf  = 1'b0;
        alu_br   = 1'b0;
        alu_tk   = 1'b0;
        case (in_opcode)
            OPC_W'(FUNCT_ADD): begin
                alu_data = sum;
                alu_ovf  = (in_rsdata[MSB] == in_rtdata[MSB]) && (sum[MSB] != in_rsdata[MSB]);
            end
            OPC_W'(FUNCT_ADDU): alu_data = sum;
            OPC_W'(FUNCT_SUB): begin
                alu_data = diff;
                alu_ovf  = (in_rsdata[MSB] != in_rtdata[MSB]) && (diff[MSB] != in_rsdata[MSB]);
            end
            OPC_W'(FUNCT_SUBU): alu_data = diff;
            OPC_W'(FUNCT_AND):  alu_data = in_rsdata & in_rtdata;
            OPC_W'(FUNCT_OR):   alu_data = in_rsdata | in_rtdata;
            OPC_W'(FUNCT_XOR):  alu_data = in_rsdata ^ in_rtdata;
            OPC_W'(FUNCT_NOR):  alu_data = ~(in_rsdata | in_rtdata);
            OPC_W'(FUNCT_SLT):  alu_data = {{(DATA_W-1){1'b0}}, slt};
            OPC_W'(FUNCT_SLTU): alu_data = {{(DATA_W-1){1'b0}}, sltu};
            OPC_W'(FUNCT_SLL):  alu_data = in_rtdata << shamt;
            OPC_W'(FUNCT_SRL):  alu_data = in_rtdata >> shamt;
            OPC_W'(FUNCT_SRA):  alu_data = rt_s >>> shamt;
            OPC_W'(OPCODE_BEQ): begin
                alu_br = 1'b1;
                alu_tk = (in_rsdata == in_rtdata);
            end
            OPC_W'(OPCODE_BNE): begin
                alu_br = 1'b1;
                alu_tk = (in_rsdata != in_rtdata);
            end
            default: ;
        endcase
    end

    assign alu_entry = {alu_data, in_rdtag, alu_tk, alu_br, alu_ovf};

    logic              ex_valid_q;
    logic [ENT_W-1:0]  ex_entry_q;
    logic              q_empty, q_full, q_pop, ex_to_q, ex_done, bypass, grant, accept;
    logic [ENT_W-1:0]  q_rdata, head;
    logic [QCNT_W-1:0] q_count;

`ifdef ISSUEINT_BYPASS_EN
    assign bypass = q_empty && ex_valid_q;
`else
    assign bypass = 1'b0;
`endif

    assign head      = bypass ? ex_entry_q : q_rdata;
    assign out_valid = !q_empty || bypass;
    assign grant     = out_valid && out_ready;
    assign q_pop     = grant && !bypass;
    // A granted bypass entry retires straight from EX and never enters the queue.
    assign ex_to_q   = ex_valid_q && !(bypass && out_ready) && (!q_full || q_pop);
    assign ex_done   = ex_to_q || (bypass && out_ready);
    assign in_ready  = !flush && (!ex_valid_q || !q_full || grant);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_entry_q <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_entry_q <= alu_entry;
        end else if (ex_done) begin
            ex_valid_q <= 1'b0;
        end
    end

    issueint_resq #(
        .WIDTH (ENT_W),
        .DEPTH (QDEPTH)
    ) u_resq (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (ex_to_q),
        .pop   (q_pop),
        .wdata (ex_entry_q),
        .rdata (q_rdata),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    assign out_data         = out_valid ? head[ENT_W-1 -: DATA_W] : '0;
    assign out_rdtag        = out_valid ? head[ENT_FLAG_W +: TAG_W] : '0;
    assign out_overflow     = out_valid && head[ENT_OVF];
    assign out_branch       = out_valid && head[ENT_BR];
    assign out_branch_taken = out_valid && head[ENT_TAKEN];
    assign out_count        = CNT_W'(ex_valid_q) + CNT_W'(q_count);

endmodule

// File: tb/tb_issueint_pipe.sv
// Self-checking bench for issueint_pipe: directed ops, back-pressure, flush and a
// randomized stream checked against a transaction-level scoreboard.
module tb_issueint_pipe;
    import issueint_pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int OPC_W  = 6;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = $clog2(QDEPTH + 2);
`ifdef ISSUEINT_BYPASS_EN
    localparam int AGE_MIN = 0;
`else
    localparam int AGE_MIN = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode = '0;
    logic [DATA_W-1:0] in_rsdata = '0;
    logic [DATA_W-1:0] in_rtdata = '0;
    logic [TAG_W-1:0]  in_rdtag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_rdtag;
    logic              out_overflow, out_branch, out_branch_taken;
    logic [CNT_W-1:0]  out_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issueint_pipe #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .OPC_W  (OPC_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_opcode        (in_opcode),
        .in_rsdata        (in_rsdata),
        .in_rtdata        (in_rtdata),
        .in_rdtag         (in_rdtag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_rdtag        (out_rdtag),
        .out_overflow     (out_overflow),
        .out_branch       (out_branch),
        .out_branch_taken (out_branch_taken),
        .out_count        (out_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        br;
        logic        tk;
    } res_t;

    typedef struct {
        res_t       r;
        logic [5:0] tag;
        int         acc;
    } mq_t;

    // Reference ALU using wide signed integer arithmetic.
    function automatic res_t ref_alu(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        res_t   r;
        longint sa, sb, s, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            FUNCT_ADD: begin
                s = sa + sb;
                r.data = s[31:0];
                r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            FUNCT_SUB: begin
                s = sa - sb;
                r.data = s[31:0];
                r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            FUNCT_ADDU: begin s = ua + ub; r.data = s[31:0]; end
            FUNCT_SUBU: begin s = ua - ub; r.data = s[31:0]; end
            FUNCT_AND:  r.data = a & b;
            FUNCT_OR:   r.data = a | b;
            FUNCT_XOR:  r.data = a ^ b;
            FUNCT_NOR:  r.data = ~(a | b);
            FUNCT_SLT:  r.data = (sa < sb) ? 32'd1 : 32'd0;
            FUNCT_SLTU: r.data = (ua < ub) ? 32'd1 : 32'd0;
            FUNCT_SLL:  begin s = ub * (64'sd1 << a[4:0]); r.data = s[31:0]; end
            FUNCT_SRL:  begin s = ub / (64'sd1 << a[4:0]); r.data = s[31:0]; end
            FUNCT_SRA:  begin s = sb >>> a[4:0]; r.data = s[31:0]; end
            OPCODE_BEQ: begin r.br = 1'b1; r.tk = (a == b); end
            OPCODE_BNE: begin r.br = 1'b1; r.tk = (a != b); end
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_unit();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++;
        if (out_count !== '0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
        n_tests++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        tick();
    endtask

    task automatic test_ops();
        logic [5:0]  ops [11] = '{FUNCT_ADD, FUNCT_ADDU, FUNCT_SLT, FUNCT_SLTU, FUNCT_SRA,
                                  OPCODE_BEQ, OPCODE_BNE, FUNCT_XOR, FUNCT_SUB, 6'h3f, FUNCT_ADD};
        logic [31:0] rs  [11] = '{32'h7fffffff, 32'h7fffffff, 32'hffffffff, 32'hffffffff, 32'd4,
                                  32'd3, 32'd3, 32'h0000f0f0, 32'h80000000, 32'd5, 32'd2};
        logic [31:0] rt  [11] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h80000000,
                                  32'd3, 32'd3, 32'h00000ff0, 32'd1, 32'd5, 32'd3};
        logic [31:0] exd [11] = '{32'h80000000, 32'h80000000, 32'd1, 32'd0, 32'hf8000000,
                                  32'd0, 32'd0, 32'h0000ff00, 32'h7fffffff, 32'd0, 32'd5};
        logic [2:0]  exf [11] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000,
                                  3'b011, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
        int lat;
        for (int i = 0; i < 11; i++) begin
            in_valid  = 1'b1;
            in_opcode = ops[i];
            in_rsdata = rs[i];
            in_rtdata = rt[i];
            in_rdtag  = (i == 0) ? 6'd5 : 6'(i + 8);
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 6) begin
                tick();
                lat++;
            end
            n_tests++;
            if (lat !== AGE_MIN) begin
                n_fail++; $display("FAIL op%0d_latency got %0d want %0d", i, lat, AGE_MIN);
            end
            n_tests++;
            if (out_data !== exd[i]) begin
                n_fail++; $display("FAIL op%0d_data got %h want %h", i, out_data, exd[i]);
            end
            n_tests++;
            if ({out_overflow, out_branch, out_branch_taken} !== exf[i]) begin
                n_fail++;
                $display("FAIL op%0d_flags got %b want %b", i,
                         {out_overflow, out_branch, out_branch_taken}, exf[i]);
            end
            n_tests++;
            if (out_rdtag !== in_rdtag) begin
                n_fail++; $display("FAIL op%0d_tag got %0d want %0d", i, out_rdtag, in_rdtag);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int          accepts = 0;
        logic [5:0]  exp_tags[$];
        logic [5:0]  got_tags[$];
        logic [31:0] got_data[$];
        clear_unit();
        out_ready = 1'b0;
        in_opcode = FUNCT_ADDU;
        in_rtdata = 32'd1000;
        for (int i = 0; i < QDEPTH + 2; i++) begin
            in_valid  = 1'b1;
            in_rdtag  = 6'(i);
            in_rsdata = 32'(i * 3);
            #1;
            if (in_ready) begin
                accepts++;
                exp_tags.push_back(6'(i));
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (accepts !== QDEPTH + 1) begin
            n_fail++; $display("FAIL bp_accepts got %0d want %0d", accepts, QDEPTH + 1);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
        // Full unit, simultaneous push and pop.
        in_rdtag  = 6'd20;
        in_rsdata = 32'd60;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready got %0b want 1", in_ready); end
        if (in_ready) exp_tags.push_back(6'd20);
        if (out_valid) begin got_tags.push_back(out_rdtag); got_data.push_back(out_data); end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_count !== CNT_W'(QDEPTH + 1)) begin
            n_fail++; $display("FAIL full_pushpop_count got %0d want %0d", out_count, QDEPTH + 1);
        end
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin got_tags.push_back(out_rdtag); got_data.push_back(out_data); end
            tick();
        end
        n_tests++;
        if (got_tags.size() !== exp_tags.size()) begin
            n_fail++; $display("FAIL drain_count got %0d want %0d", got_tags.size(), exp_tags.size());
        end else begin
            for (int i = 0; i < exp_tags.size(); i++) begin
                n_tests++;
                if (got_tags[i] !== exp_tags[i] ||
                    got_data[i] !== 32'(exp_tags[i]) * 32'd3 + 32'd1000) begin
                    n_fail++;
                    $display("FAIL drain_order[%0d] got tag %0d data %0d want tag %0d data %0d", i,
                             got_tags[i], got_data[i], exp_tags[i], exp_tags[i] * 3 + 1000);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int stalls = 0;
        clear_unit();
        out_ready = 1'b1;
        in_opcode = FUNCT_XOR;
        in_rtdata = 32'h5a5a0000;
        for (int c = 0; c < 3 * QDEPTH + 6; c++) begin
            in_valid = (c < 3 * QDEPTH);
            in_rdtag = 6'(c);
            in_rsdata = 32'(c);
            #1;
            if (in_valid && !in_ready) stalls++;
            if (out_valid) begin
                n_tests++;
                if (out_rdtag !== 6'(got) || out_data !== (32'h5a5a0000 ^ 32'(got))) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d] got tag %0d data %h want tag %0d", got,
                             out_rdtag, out_data, got);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        n_tests++;
        if (got !== 3 * QDEPTH) begin n_fail++; $display("FAIL b2b_retired got %0d want %0d", got, 3 * QDEPTH); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        int seen = 0;
        clear_unit();
        out_ready = 1'b0;
        in_opcode = FUNCT_ADDU;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_rdtag = 6'(i + 1);
            tick();
        end
        in_rdtag = 6'h2a;
        flush = 1'b1;
        #1;
        n_tests++;
        if (out_count !== CNT_W'(3)) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", out_count); end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (out_count !== '0) begin n_fail++; $display("FAIL flush_count got %0d want 0", out_count); end
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL flush_dropped got %0d results want 0", seen); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0]  ops [16] = '{FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR,
                                  FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU, FUNCT_SLL, FUNCT_SRL,
                                  FUNCT_SRA, OPCODE_BEQ, OPCODE_BNE, 6'h3e};
        logic [31:0] edge_vals [5] = '{32'd0, 32'd1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
        mq_t  mq[$];
        mq_t  e;
        int   cyc = 0;
        int   errs = 0;
        logic head_vis, exp_ready;
        clear_unit();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_opcode = ops[$urandom % 16];
            in_rsdata = ($urandom % 3 == 0) ? edge_vals[$urandom % 5] : $urandom;
            in_rtdata = ($urandom % 3 == 0) ? edge_vals[$urandom % 5] : $urandom;
            if ($urandom % 5 == 0) in_rtdata = in_rsdata;
            in_rdtag  = 6'($urandom);
            out_ready = ($urandom % 2) != 0;
            flush     = ($urandom % 40) == 0;
            #1;
            head_vis  = (mq.size() > 0) && (cyc - mq[0].acc >= AGE_MIN);
            exp_ready = !flush && ((mq.size() < QDEPTH + 1) || (head_vis && out_ready));
            n_tests++;
            if (in_ready !== exp_ready || out_valid !== head_vis ||
                out_count !== CNT_W'(mq.size())) begin
                n_fail++; errs++;
                if (errs < 10)
                    $display("FAIL rand_ctrl cyc %0d got rdy %0b vld %0b cnt %0d want %0b %0b %0d",
                             c, in_ready, out_valid, out_count, exp_ready, head_vis, mq.size());
            end
            if (head_vis) begin
                n_tests++;
                if (out_data !== mq[0].r.data || out_rdtag !== mq[0].tag ||
                    {out_overflow, out_branch, out_branch_taken} !==
                    {mq[0].r.ovf, mq[0].r.br, mq[0].r.tk}) begin
                    n_fail++; errs++;
                    if (errs < 10)
                        $display("FAIL rand_result cyc %0d got %h/%0d/%b want %h/%0d/%b", c,
                                 out_data, out_rdtag, {out_overflow, out_branch, out_branch_taken},
                                 mq[0].r.data, mq[0].tag, {mq[0].r.ovf, mq[0].r.br, mq[0].r.tk});
                end
            end
            @(posedge clk);
            cyc++;
            if (flush) begin
                mq.delete();
            end else begin
                if (head_vis && out_ready) void'(mq.pop_front());
                if (in_valid && exp_ready) begin
                    e.r   = ref_alu(in_opcode, in_rsdata, in_rtdata);
                    e.tag = in_rdtag;
                    e.acc = cyc;
                    mq.push_back(e);
                end
            end
            #1;
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
